// File: rtl/prog_clkdiv_pkg.sv
// Shared constants and the duty-cycle helper for the programmable clock divider.
package prog_clkdiv_pkg;

    localparam int DIV_W_DEFAULT = 8;
    localparam int MIN_DIV       = 2;

    // Number of high cycles in one period: ceil(div/2), so odd divisors lean high.
    function automatic logic [31:0] hiCycles(input logic [31:0] div);
        return (div >> 1) + {31'b0, div[0]};
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: period counter, active/queued divisor, and registered clk/tick outputs.
module clkdiv_channel
    import prog_clkdiv_pkg::*;
#(
    parameter int DIV_W     = DIV_W_DEFAULT,
    parameter int RESET_DIV = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             clk_o,
    output logic             tick_o,
    output logic             pending_o
);

    localparam logic [DIV_W-1:0] MIN_DIV_V = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0] RST_DIV   = DIV_W'(RESET_DIV);
    localparam logic [DIV_W-1:0] RST_CNT   = (RESET_DIV >= MIN_DIV) ? DIV_W'(RESET_DIV - 1) : '0;

    logic [DIV_W-1:0] activeDiv_q, activeDiv_d;
    logic [DIV_W-1:0] newDiv_q, newDiv_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             clkOut_q, clkOut_d;
    logic             tick_q, tick_d;
    logic             pending_q, pending_d;

    logic [DIV_W-1:0] hi;
    logic [DIV_W-1:0] cntInc;
    logic [DIV_W-1:0] nextDiv;
    logic             enabled;
    logic             wrap;

    assign hi      = DIV_W'(hiCycles(32'(activeDiv_q)));
    assign cntInc  = cnt_q + DIV_W'(1);
    assign enabled = (activeDiv_q >= MIN_DIV_V);
    assign wrap    = (cnt_q == activeDiv_q - DIV_W'(1));
    assign nextDiv = pending_q ? newDiv_q : activeDiv_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            activeDiv_q <= RST_DIV;
            newDiv_q    <= '0;
            cnt_q       <= RST_CNT;
            clkOut_q    <= 1'b0;
            tick_q      <= 1'b0;
            pending_q   <= 1'b0;
        end else begin
            activeDiv_q <= activeDiv_d;
            newDiv_q    <= newDiv_d;
            cnt_q       <= cnt_d;
            clkOut_q    <= clkOut_d;
            tick_q      <= tick_d;
            pending_q   <= pending_d;
        end
    end

    // Divisor swaps only happen at a wrap (or straight away while disabled), so no phase is ever cut short.
    always_comb begin
        activeDiv_d = activeDiv_q;
        newDiv_d    = newDiv_q;
        cnt_d       = cnt_q;
        clkOut_d    = clkOut_q;
        tick_d      = 1'b0;
        pending_d   = pending_q;

        if (enabled) begin
            if (wrap) begin
                cnt_d = '0;
                if (pending_q) begin
                    activeDiv_d = newDiv_q;
                    pending_d   = 1'b0;
                end
                clkOut_d = (nextDiv >= MIN_DIV_V);
                tick_d   = (nextDiv >= MIN_DIV_V);
            end else begin
                cnt_d    = cntInc;
                clkOut_d = (cntInc < hi);
            end
        end else begin
            clkOut_d = 1'b0;
            cnt_d    = '0;
            if (pending_q) begin
                activeDiv_d = newDiv_q;
                pending_d   = 1'b0;
                cnt_d       = (newDiv_q >= MIN_DIV_V) ? newDiv_q - DIV_W'(1) : '0;
            end
        end

        // Loads are only granted while nothing is queued, so this never collides with an apply.
        if (load_i) begin
            newDiv_d  = div_i;
            pending_d = 1'b1;
        end
    end

    assign clk_o     = clkOut_q;
    assign tick_o    = tick_q;
    assign pending_o = pending_q;

endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider: config port decode plus NUM_CH independent channels.
module prog_clock_divider
    import prog_clkdiv_pkg::*;
#(
    parameter int  NUM_CH    = 4,
    parameter int  DIV_W     = DIV_W_DEFAULT,
    parameter int  RESET_DIV = 4,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending
);

    logic              chReady;
    logic [NUM_CH-1:0] load;

    // Unmatched (out-of-range) channel indices leave ready high and load nothing, dropping the write.
    always_comb begin
        chReady = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                chReady = !pending[i];
            end
        end
    end

    assign cfg_ready = chReady;

    for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
        assign load[g] = cfg_valid && chReady && (cfg_ch == CH_W'(g));

        clkdiv_channel #(
            .DIV_W     (DIV_W),
            .RESET_DIV (RESET_DIV)
        ) u_ch (
            .clk_i     (clk_in),
            .rst_ni    (rst_n),
            .load_i    (load[g]),
            .div_i     (cfg_div),
            .clk_o     (clk_out[g]),
            .tick_o    (tick[g]),
            .pending_o (pending[g])
        );
    end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed self-checking bench for prog_clock_divider (4 channels, 8-bit divisors, reset divisor 4).
module tb_prog_clock_divider;

    localparam int NUM_CH    = 4;
    localparam int DIV_W     = 8;
    localparam int RESET_DIV = 4;

    logic              clk_in    = 1'b0;
    logic              rst_n     = 1'b0;
    logic              cfg_valid = 1'b0;
    logic [1:0]        cfg_ch    = '0;
    logic [DIV_W-1:0]  cfg_div   = '0;
    logic              cfg_ready;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] pending;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk_in = ~clk_in;

    prog_clock_divider #(
        .NUM_CH    (NUM_CH),
        .DIV_W     (DIV_W),
        .RESET_DIV (RESET_DIV)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .clk_out   (clk_out),
        .tick      (tick),
        .pending   (pending)
    );

    // Outputs are sampled 1ns after each rising edge; inputs change at the same point.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Leaves rst_n released just after a posedge, so the next posedge is edge 1.
    task automatic applyReset();
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] expClk;
        logic [7:0] expTick;
        expClk  = 8'b11001100;
        expTick = 8'b10001000;
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        step();
        vectors++;
        if ({clk_out, tick, pending} !== 12'h000) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got %b want %b", {clk_out, tick, pending}, 12'h000);
        end
        vectors++;
        if (cfg_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_ready: got %b want 1", cfg_ready);
        end
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            vectors++;
            if (clk_out !== {4{expClk[7-k]}}) begin
                miscompares++;
                $display("[TB] FAIL reset_clk edge%0d: got %b want %b", k + 1, clk_out, {4{expClk[7-k]}});
            end
            vectors++;
            if (tick !== {4{expTick[7-k]}}) begin
                miscompares++;
                $display("[TB] FAIL reset_tick edge%0d: got %b want %b", k + 1, tick, {4{expTick[7-k]}});
            end
        end
    endtask

    task automatic test_div5_midperiod();
        logic [8:0] expClk1;
        logic [8:0] expClk0;
        logic [8:0] expPend1;
        logic [8:0] expTick1;
        expClk1  = 9'b100111001;
        expClk0  = 9'b100110011;
        expPend1 = 9'b111000000;
        expTick1 = 9'b000100001;
        applyReset();
        step();
        cfg_ch    = 2'd1;
        cfg_div   = 8'd5;
        cfg_valid = 1'b1;
        vectors++;
        if (cfg_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL div5_ready_before: got %b want 1", cfg_ready);
        end
        for (int k = 0; k < 9; k++) begin
            step();
            cfg_valid = 1'b0;
            vectors++;
            if (clk_out[1] !== expClk1[8-k]) begin
                miscompares++;
                $display("[TB] FAIL div5_clk1 edge%0d: got %b want %b", k + 2, clk_out[1], expClk1[8-k]);
            end
            vectors++;
            if (clk_out[0] !== expClk0[8-k]) begin
                miscompares++;
                $display("[TB] FAIL div5_clk0 edge%0d: got %b want %b", k + 2, clk_out[0], expClk0[8-k]);
            end
            vectors++;
            if (tick[1] !== expTick1[8-k]) begin
                miscompares++;
                $display("[TB] FAIL div5_tick1 edge%0d: got %b want %b", k + 2, tick[1], expTick1[8-k]);
            end
            vectors++;
            if ({pending, cfg_ready} !== {2'b00, expPend1[8-k], 1'b0, !expPend1[8-k]}) begin
                miscompares++;
                $display("[TB] FAIL div5_pend_ready edge%0d: got %b want %b", k + 2, {pending, cfg_ready},
                         {2'b00, expPend1[8-k], 1'b0, !expPend1[8-k]});
            end
        end
    endtask

    task automatic test_disable_reenable();
        logic [4:0] expClkA;
        logic [4:0] expPendA;
        logic [8:0] expClkB;
        logic [8:0] expTickB;
        logic [8:0] expPendB;
        expClkA  = 5'b10000;
        expPendA = 5'b11100;
        expClkB  = 9'b001110001;
        expTickB = 9'b001000001;
        expPendB = 9'b100000000;
        applyReset();
        step();
        cfg_ch    = 2'd2;
        cfg_div   = 8'd0;
        cfg_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            cfg_valid = 1'b0;
            vectors++;
            if ({clk_out[2], tick[2], pending[2]} !== {expClkA[4-k], 1'b0, expPendA[4-k]}) begin
                miscompares++;
                $display("[TB] FAIL div0_ch2 edge%0d: got %b want %b", k + 2, {clk_out[2], tick[2], pending[2]},
                         {expClkA[4-k], 1'b0, expPendA[4-k]});
            end
        end
        cfg_div   = 8'd6;
        cfg_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step();
            cfg_valid = 1'b0;
            vectors++;
            if ({clk_out[2], tick[2], pending[2]} !== {expClkB[8-k], expTickB[8-k], expPendB[8-k]}) begin
                miscompares++;
                $display("[TB] FAIL div6_ch2 edge%0d: got %b want %b", k + 7, {clk_out[2], tick[2], pending[2]},
                         {expClkB[8-k], expTickB[8-k], expPendB[8-k]});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [14:0] expClk0;
        logic [14:0] expTick0;
        logic [14:0] expPend0;
        expClk0  = 15'b110011011110001;
        expTick0 = 15'b100010010000001;
        expPend0 = 15'b011101100000000;
        applyReset();
        cfg_ch = 2'd0;
        for (int k = 0; k < 15; k++) begin
            step();
            vectors++;
            if ({clk_out[0], tick[0], pending[0], cfg_ready} !==
                {expClk0[14-k], expTick0[14-k], expPend0[14-k], !expPend0[14-k]}) begin
                miscompares++;
                $display("[TB] FAIL b2b_ch0 edge%0d: got %b want %b", k + 1,
                         {clk_out[0], tick[0], pending[0], cfg_ready},
                         {expClk0[14-k], expTick0[14-k], expPend0[14-k], !expPend0[14-k]});
            end
            if (k == 0) begin
                cfg_div   = 8'd3;
                cfg_valid = 1'b1;
            end else if (k == 1) begin
                cfg_div = 8'd7;
            end else if (k == 5) begin
                cfg_valid = 1'b0;
            end
        end
    endtask

    task automatic test_wrap_edge();
        logic [11:0] expClk3;
        logic [11:0] expTick3;
        logic [11:0] expPend3;
        expClk3  = 12'b110011001010;
        expTick3 = 12'b100010001010;
        expPend3 = 12'b000011110000;
        applyReset();
        for (int k = 0; k < 12; k++) begin
            step();
            vectors++;
            if ({clk_out[3], tick[3], pending[3]} !== {expClk3[11-k], expTick3[11-k], expPend3[11-k]}) begin
                miscompares++;
                $display("[TB] FAIL wrap_ch3 edge%0d: got %b want %b", k + 1, {clk_out[3], tick[3], pending[3]},
                         {expClk3[11-k], expTick3[11-k], expPend3[11-k]});
            end
            if (k == 3) begin
                cfg_ch    = 2'd3;
                cfg_div   = 8'd2;
                cfg_valid = 1'b1;
            end else if (k == 4) begin
                cfg_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset_midperiod();
        logic [7:0] expClk;
        logic [7:0] expTick;
        expClk  = 8'b11001100;
        expTick = 8'b10001000;
        applyReset();
        cfg_ch    = 2'd1;
        cfg_div   = 8'd5;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        vectors++;
        if ({clk_out, tick, pending} !== 12'b1111_1111_0010) begin
            miscompares++;
            $display("[TB] FAIL midrst_pre: got %b want %b", {clk_out, tick, pending}, 12'b1111_1111_0010);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({clk_out, tick, pending} !== 12'h000) begin
            miscompares++;
            $display("[TB] FAIL midrst_async: got %b want %b", {clk_out, tick, pending}, 12'h000);
        end
        step();
        vectors++;
        if ({clk_out, tick, pending} !== 12'h000) begin
            miscompares++;
            $display("[TB] FAIL midrst_held: got %b want %b", {clk_out, tick, pending}, 12'h000);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            vectors++;
            if ({clk_out, tick, pending} !== {{4{expClk[7-k]}}, {4{expTick[7-k]}}, 4'b0000}) begin
                miscompares++;
                $display("[TB] FAIL midrst_replay edge%0d: got %b want %b", k + 1, {clk_out, tick, pending},
                         {{4{expClk[7-k]}}, {4{expTick[7-k]}}, 4'b0000});
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached before summary");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_div5_midperiod();
        test_disable_reenable();
        test_back_to_back();
        test_wrap_edge();
        test_reset_midperiod();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
